// File: rtl/mux_pkg.sv
// Shared types and default sizes for the unpack_s3 lane serializer.
package mux_pkg;

  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SEQ = 1'b1} mux_mode_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} mux_state_t;

  localparam int MUX_WIDTH_DEF  = 8;
  localparam int MUX_NUM_IN_DEF = 4;

endpackage

// File: rtl/mux_nin_o1.sv
// Combinational NUM_IN:1 lane selector built as a binary tree of 2:1 muxes.
module mux_nin_o1 #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] word_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        lane_o
);

  // Heap layout: node p has children 2p+1/2p+2, leaves sit at NUM_IN-1+k so
  // adjacent lanes pair up at the first level, which is steered by sel_i[0].
  logic [(2*NUM_IN-1)*WIDTH-1:0] tree;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_leaf
    assign tree[(NUM_IN-1+k)*WIDTH +: WIDTH] = word_i[k*WIDTH +: WIDTH];
  end

  for (genvar lvl = 1; lvl <= SEL_W; lvl++) begin : g_lvl
    for (genvar j = 0; j < (NUM_IN >> lvl); j++) begin : g_node
      localparam int P = (NUM_IN >> lvl) - 1 + j;
      assign tree[P*WIDTH +: WIDTH] = sel_i[lvl-1] ? tree[(2*P+2)*WIDTH +: WIDTH]
                                                   : tree[(2*P+1)*WIDTH +: WIDTH];
    end
  end

  assign lane_o = tree[WIDTH-1:0];

endmodule

// File: rtl/mux_lane_serializer.sv
// Registered N-to-1 lane serializer: emits one selected lane (DIRECT) or all lanes in order (SEQ).
//   state   | meaning
//   IDLE    | no word held, out_valid low, in_ready high
//   EMIT    | word held, lane[idx] presented on the output stream
module mux_lane_serializer import mux_pkg::*; #(
  parameter int WIDTH  = MUX_WIDTH_DEF,
  parameter int NUM_IN = MUX_NUM_IN_DEF,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_mode,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_idx,
  output logic                    out_last
);

  mux_state_t              state_q, state_d;
  mux_mode_t               mode_q, mode_d;
  logic [NUM_IN*WIDTH-1:0] word_q, word_d;
  logic [SEL_W-1:0]        idx_q, idx_d;

  logic             emit;
  logic             last;
  logic             in_fire;
  logic             out_fire;
  logic             load;
  logic [WIDTH-1:0] lane_sel;

  mux_nin_o1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .word_i (word_q),
    .sel_i  (idx_q),
    .lane_o (lane_sel)
  );

  assign emit     = (state_q == ST_EMIT);
  assign last     = emit && ((mode_q == MODE_DIRECT) || (idx_q == SEL_W'(NUM_IN-1)));
  assign out_valid = emit;
  assign out_last  = last;
  assign out_idx   = emit ? idx_q : '0;
  assign out_data  = emit ? lane_sel : '0;
  assign in_ready  = !emit || (out_ready && last);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = emit && out_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    word_d  = word_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) load = 1'b1;
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (!last)        idx_d   = idx_q + SEL_W'(1);
          else if (in_fire) load    = 1'b1;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A reload in the last-beat cycle keeps EMIT so consecutive words have no bubble.
    if (load) begin
      state_d = ST_EMIT;
      word_d  = in_data;
      mode_d  = mux_mode_t'(in_mode);
      idx_d   = in_mode ? '0 : in_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_DIRECT;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_mux_lane_serializer.sv
// Directed bench for mux_lane_serializer: default 8x4 instance plus a 16x8 instance.
module tb_mux_lane_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_last;
  logic [31:0] a_in_data;
  logic [1:0]  a_in_sel, a_out_idx;
  logic [7:0]  a_out_data;

  logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_last;
  logic [127:0] b_in_data;
  logic [2:0]   b_in_sel, b_out_idx;
  logic [15:0]  b_out_data;

  int total = 0;
  int bad   = 0;

  mux_lane_serializer #(.WIDTH(8), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_last(a_out_last)
  );

  mux_lane_serializer #(.WIDTH(16), .NUM_IN(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", a_out_data); end
    total++; if (a_out_idx !== 2'd0) begin bad++; $display("FAIL rst_out_idx got=%0d exp=0", a_out_idx); end
    total++; if (a_out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", a_out_last); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
    total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_b got valid=%b ready=%b exp valid=0 ready=1", b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_mode = 1'b1; a_in_sel = 2'd0; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    total++; if (a_out_idx !== 2'd2 || a_out_data !== 8'h33) begin
      bad++; $display("FAIL midrst_pre got idx=%0d data=%h exp idx=2 data=33", a_out_idx, a_out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_idx !== 2'd0 || a_out_last !== 1'b0) begin
      bad++; $display("FAIL midrst_async got v=%b d=%h i=%0d l=%b exp all 0",
                      a_out_valid, a_out_data, a_out_idx, a_out_last);
    end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", a_in_ready); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_after c=%0d got valid=%b exp=0", c, a_out_valid); end
    end
  endtask

  task automatic test_direct();
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; a_in_mode = 1'b0; a_in_sel = 2'd2; a_out_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL direct_ready_idle got=%b exp=1", a_in_ready); end
    step();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hCC || a_out_idx !== 2'd2 || a_out_last !== 1'b1) begin
      bad++; $display("FAIL direct_beat got v=%b d=%h i=%0d l=%b exp v=1 d=cc i=2 l=1",
                      a_out_valid, a_out_data, a_out_idx, a_out_last);
    end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL direct_ready_last got=%b exp=1", a_in_ready); end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL direct_done got valid=%b exp=0", a_out_valid); end
  endtask

  task automatic test_seq();
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_mode = 1'b1; a_in_sel = 2'd3; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h11 * (k + 1)) || a_out_idx !== 2'(k)
                   || a_out_last !== (k == 3)) begin
        bad++; $display("FAIL seq_beat%0d got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b", k,
                        a_out_valid, a_out_data, a_out_idx, a_out_last, 8'(8'h11 * (k + 1)), k, (k == 3));
      end
      total++; if (a_in_ready !== (k == 3)) begin
        bad++; $display("FAIL seq_ready%0d got=%b exp=%b", k, a_in_ready, (k == 3));
      end
      step();
    end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL seq_done got valid=%b exp=0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_mode = 1'b1; a_in_sel = 2'd0; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin a_in_valid = 1'b1; a_in_data = 32'h88776655; a_in_mode = 1'b1; #1; end
      total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h11 * (k + 1)) || a_out_idx !== 2'(k % 4)
                   || a_out_last !== (k % 4 == 3)) begin
        bad++; $display("FAIL b2b_beat%0d got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b", k,
                        a_out_valid, a_out_data, a_out_idx, a_out_last, 8'(8'h11 * (k + 1)), k % 4, (k % 4 == 3));
      end
      step();
      a_in_valid = 1'b0;
    end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_done got valid=%b exp=0", a_out_valid); end
    // DIRECT words at one per cycle with in_valid held
    a_in_valid = 1'b1; a_in_data = 32'hDDCCBBAA; a_in_mode = 1'b0; a_in_sel = 2'd0;
    step();
    a_in_sel = 2'd3;
    total++; if (a_out_data !== 8'hAA || a_out_idx !== 2'd0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL dir_b2b0 got d=%h i=%0d rdy=%b exp d=aa i=0 rdy=1", a_out_data, a_out_idx, a_in_ready);
    end
    step();
    a_in_valid = 1'b0;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hDD || a_out_idx !== 2'd3 || a_out_last !== 1'b1) begin
      bad++; $display("FAIL dir_b2b1 got v=%b d=%h i=%0d l=%b exp v=1 d=dd i=3 l=1",
                      a_out_valid, a_out_data, a_out_idx, a_out_last);
    end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL dir_b2b_done got valid=%b exp=0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    a_in_valid = 1'b1; a_in_data = 32'h44332211; a_in_mode = 1'b1; a_in_sel = 2'd0; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    total++; if (a_out_data !== 8'h11) begin bad++; $display("FAIL bp_beat0 got=%h exp=11", a_out_data); end
    step();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'hEEEEEEEE;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h22 || a_out_idx !== 2'd1 || a_out_last !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b d=%h i=%0d l=%b exp v=1 d=22 i=1 l=0", c,
                        a_out_valid, a_out_data, a_out_idx, a_out_last);
      end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", c, a_in_ready); end
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    #1;
    total++; if (a_out_data !== 8'h22) begin bad++; $display("FAIL bp_resume22 got=%h exp=22", a_out_data); end
    step();
    total++; if (a_out_data !== 8'h33 || a_out_idx !== 2'd2) begin
      bad++; $display("FAIL bp_resume33 got d=%h i=%0d exp d=33 i=2", a_out_data, a_out_idx);
    end
    step();
    total++; if (a_out_data !== 8'h44 || a_out_last !== 1'b1) begin
      bad++; $display("FAIL bp_last got d=%h l=%b exp d=44 l=1", a_out_data, a_out_last);
    end
    step();
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bp_done got valid=%b exp=0", a_out_valid); end
  endtask

  task automatic test_param_sweep();
    for (int k = 0; k < 8; k++) b_in_data[k*16 +: 16] = 16'h1000 + 16'(k);
    b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_sel = 3'd5; b_out_ready = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h1000 + 16'(k) || b_out_idx !== 3'(k)
                   || b_out_last !== (k == 7)) begin
        bad++; $display("FAIL sweep_seq%0d got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b", k,
                        b_out_valid, b_out_data, b_out_idx, b_out_last, 16'h1000 + 16'(k), k, (k == 7));
      end
      step();
    end
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_seq_done got valid=%b exp=0", b_out_valid); end
    b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_sel = 3'd7;
    step();
    b_in_valid = 1'b0;
    total++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h1007 || b_out_idx !== 3'd7 || b_out_last !== 1'b1) begin
      bad++; $display("FAIL sweep_direct got v=%b d=%h i=%0d l=%b exp v=1 d=1007 i=7 l=1",
                      b_out_valid, b_out_data, b_out_idx, b_out_last);
    end
    step();
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL sweep_direct_done got valid=%b exp=0", b_out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_in_sel = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;
    #3;
    test_reset();
    step();
    rst_n = 1'b1;
    step();
    test_direct();
    test_seq();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_lane_serializer.md
# mux_lane_serializer

Registered, parametrised N-to-1 lane multiplexer for the unpack_s3 datapath. It accepts one packed word of NUM_IN lanes, each WIDTH bits wide, through a valid/ready handshake. It then emits either one selected lane (direct mode) or every lane in ascending order, one per cycle (sequential mode), on a valid/ready output stream. This lets the trit-unpack stage consume packed bytes without a wide combinational select in its own path.

## Interface
Parameters:
- WIDTH, 8, bits per lane
- NUM_IN, 4, lanes per input word (≥2, power of two)
- SEL_W, $clog2(NUM_IN), lane index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  NUM_IN*WIDTH  lane k = in_data[k*WIDTH +: WIDTH]
- in_mode  in  1  0 = DIRECT, 1 = SEQ; sampled with the word
- in_sel  in  SEL_W  lane to emit in DIRECT mode; sampled with the word
- out_valid  out  1  output lane valid
- out_ready  in  1  downstream accepts lane
- out_data  out  WIDTH  current lane
- out_idx  out  SEL_W  index of the current lane
- out_last  out  1  current lane is the final lane of this word

## Operation
- An input transfer occurs when in_valid && in_ready. The block captures in_data, in_mode and in_sel into registers.
- An output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || (out_valid && out_ready && out_last). A new word can therefore be accepted in the same cycle the last lane of the previous word leaves.
- State machine:
  - IDLE: out_valid = 0.
    - On an input transfer, go to EMIT.
    - In DIRECT mode, set idx = in_sel.
    - In SEQ mode, set idx = 0.
  - EMIT: out_valid = 1, out_data = lane[idx], out_idx = idx.
    - out_last = 1 in DIRECT mode; in SEQ mode, out_last = 1 when idx == NUM_IN-1.
    - On an output transfer with !out_last, idx increments by 1 (SEQ mode only).
    - On an output transfer with out_last:
      - If an input transfer occurs in the same cycle, reload the word, mode and idx and stay in EMIT.
      - Otherwise go to IDLE.
    - While out_ready = 0: out_data, out_idx and out_last hold stable, and nothing changes.
- idx never wraps past NUM_IN-1. In SEQ mode the last lane ends the word.
- in_sel is ignored in SEQ mode.
- Lane selection uses the combinational sub-module below, driven by the registered idx. out_data is therefore a function of registered state only, with no input-to-output combinational path.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, in_ready = 1, state = IDLE, idx = 0, word register = 0.
- Reset asserted mid-word: the word is discarded, outputs return to their reset values immediately (asynchronously), and no partial lanes are emitted after release.
- Latency: a word accepted at edge t gives out_valid = 1 after edge t.
- DIRECT mode: one output beat per word.
- SEQ mode: NUM_IN output beats per word.
- Sustained throughput with out_ready held at 1:
  - DIRECT: one word per cycle.
  - SEQ: one word per NUM_IN cycles, with no bubble between words.
- in_ready has a combinational dependence on out_ready only.

## Structure
- Shared package mux_pkg:
  - typedef enum logic {MODE_DIRECT = 1'b0, MODE_SEQ = 1'b1} mux_mode_t
  - localparam defaults for WIDTH and NUM_IN
- One sub-module, mux_nin_o1: a parametrised (WIDTH, NUM_IN) combinational selector.
  - Inputs: the word and SEL_W select bits. Output: one lane.
  - Built as a log2(NUM_IN)-level tree of 2:1 lane muxes; select bit 0 drives the first level.

## Test plan
- **Reset:** pulse rst_n low mid-cycle -> all outputs read 0 and in_ready = 1 asynchronously. Repeat during a SEQ word at idx = 2; after release, no further lanes are emitted.
- **DIRECT:** in_data = 0xDDCCBBAA, mode 0, sel 2, out_ready = 1 -> one beat next cycle: out_data = 0xCC, out_idx = 2, out_last = 1.
- **SEQ:** in_data = 0x44332211, mode 1, out_ready = 1 -> four consecutive beats 0x11, 0x22, 0x33, 0x44 with out_idx 0..3; out_last only on 0x44; in_ready high only in the last-beat cycle.
- **Back-to-back SEQ:** two words, the second presented while the first's last lane is leaving -> eight contiguous beats with no bubble, and the second word is not lost.
- **Backpressure:** SEQ word 0x44332211, out_ready low for 3 cycles while idx = 1 -> out_data holds 0x22, in_ready stays 0, and the sequence resumes at 0x33 when out_ready rises.
- **Parameter sweep:** WIDTH = 16, NUM_IN = 8, SEQ word with lanes k = 0x1000+k -> eight beats 0x1000..0x1007; DIRECT sel = 7 -> 0x1007.
